// File: rtl/ddr3_req_scheduler.sv
// rtl/ddr3_req_scheduler.sv - single-client request scheduler for ddr3_controller
// Owns the tREFI timer with a postponement budget and issues one-cycle command pulses.
module ddr3_req_scheduler #(
  parameter int FREQ         = 78_750_000,
  parameter int REFI_NS      = 7813,
  parameter int MAX_POSTPONE = 8,
  parameter int ADDR_W       = 26
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [15:0]       req_din,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [15:0]       rsp_data,
  output logic [127:0]      rsp_data128,
  output logic              ctl_rd,
  output logic              ctl_wr,
  output logic              ctl_refresh,
  output logic [ADDR_W-1:0] ctl_addr,
  output logic [15:0]       ctl_din,
  input  logic              ctl_busy,
  input  logic              ctl_data_ready,
  input  logic [15:0]       ctl_dout,
  input  logic [127:0]      ctl_dout128,
  output logic [3:0]        refresh_debt,
  output logic              refresh_overflow
);

  localparam int REFI_CYC = (FREQ / 1000) * REFI_NS / 1_000_000;
  localparam int TW       = $clog2(REFI_CYC);
  localparam logic [TW-1:0] TICK_LAST = TW'(REFI_CYC - 1);
  localparam logic [3:0]    DEBT_MAX  = 4'(MAX_POSTPONE);

  typedef enum logic [2:0] {
    S_IDLE, S_GUARD, S_WAIT_WR, S_WAIT_RD, S_WAIT_REF
  } state_t;

  typedef enum logic [1:0] {C_WR, C_RD, C_REF} cmd_t;

  state_t              state_q, state_d;
  cmd_t                cmd_q, cmd_d;
  logic                armed_q, armed_d;
  logic [TW-1:0]       tick_q, tick_d;
  logic [3:0]          debt_q, debt_d;
  logic                ovf_q, ovf_d;
  logic                rd_q, rd_d, wr_q, wr_d, ref_q, ref_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         din_q, din_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_data_q, rsp_data_d;
  logic [127:0]        rsp128_q, rsp128_d;
  logic                got_q, got_d;
  logic                wrap, issue_ref, debt_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cmd_q       <= C_WR;
      armed_q     <= 1'b0;
      tick_q      <= '0;
      debt_q      <= '0;
      ovf_q       <= 1'b0;
      rd_q        <= 1'b0;
      wr_q        <= 1'b0;
      ref_q       <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp128_q    <= '0;
      got_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      armed_q     <= armed_d;
      tick_q      <= tick_d;
      debt_q      <= debt_d;
      ovf_q       <= ovf_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      ref_q       <= ref_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp128_q    <= rsp128_d;
      got_q       <= got_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    armed_d     = armed_q | ~ctl_busy;
    rd_d        = 1'b0;
    wr_d        = 1'b0;
    ref_d       = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    rsp128_d    = rsp128_q;
    got_d       = got_q;
    debt_d      = debt_q;
    ovf_d       = ovf_q;
    issue_ref   = 1'b0;
    debt_full   = (debt_q >= DEBT_MAX);
    wrap        = armed_q && (tick_q == TICK_LAST);
    tick_d      = (!armed_q || wrap) ? '0 : tick_q + TW'(1);
    req_ready   = armed_q && (state_q == S_IDLE) && !ctl_busy && !debt_full;

    unique case (state_q)
      S_IDLE: begin
        if (armed_q && !ctl_busy) begin
          if (debt_full) begin
            issue_ref = 1'b1;
            ref_d     = 1'b1;
            cmd_d     = C_REF;
            state_d   = S_GUARD;
          end else if (req_valid) begin
            wr_d    = req_we;
            rd_d    = !req_we;
            addr_d  = req_addr;
            din_d   = req_din;
            cmd_d   = req_we ? C_WR : C_RD;
            got_d   = 1'b0;
            state_d = S_GUARD;
          end else if (debt_q != 4'd0) begin
            issue_ref = 1'b1;
            ref_d     = 1'b1;
            cmd_d     = C_REF;
            state_d   = S_GUARD;
          end
        end
      end
      // Controller raises busy a cycle after the pulse, so busy is not trusted here.
      S_GUARD: begin
        unique case (cmd_q)
          C_WR:    state_d = S_WAIT_WR;
          C_RD:    state_d = S_WAIT_RD;
          default: state_d = S_WAIT_REF;
        endcase
      end
      S_WAIT_WR, S_WAIT_REF: begin
        if (!ctl_busy) state_d = S_IDLE;
      end
      S_WAIT_RD: begin
        if ((got_q || ctl_data_ready) && !ctl_busy) begin
          state_d = S_IDLE;
          got_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ctl_data_ready && (cmd_q == C_RD) && !got_q &&
        ((state_q == S_GUARD) || (state_q == S_WAIT_RD))) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = ctl_dout;
      rsp128_d    = ctl_dout128;
      if (state_q == S_GUARD) got_d = 1'b1;
    end

    // A wrap and an issued refresh in the same cycle cancel out.
    if (wrap && !issue_ref) begin
      if (debt_full) ovf_d = 1'b1;
      else           debt_d = debt_q + 4'd1;
    end else if (!wrap && issue_ref) begin
      debt_d = debt_q - 4'd1;
    end
  end

  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign rsp_data128      = rsp128_q;
  assign ctl_rd           = rd_q;
  assign ctl_wr           = wr_q;
  assign ctl_refresh      = ref_q;
  assign ctl_addr         = addr_q;
  assign ctl_din          = din_q;
  assign refresh_debt     = debt_q;
  assign refresh_overflow = ovf_q;

endmodule
